pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage always-taken pipeline. Drives the
//  enable/flush controls of PC, IF/ID, ID/EX and EX/MEM registers from three hazard
//  sources: load-use (EX load feeding ID), branch/jump mispredict resolved in EX,
//  and multi-cycle data-memory access (LSU busy). Small FSM adds extra flush cycles
//  after a redirect and returns to the interrupted state after a memory freeze.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles IF/ID is flushed per redirect (1..15); >1 uses FLUSH state
//  CNT_W         32  width of perf counters (PERF_CNT_EN only)
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_i          in   1      reset, synchronous, active-high
//  id_rs1_i       in   5      rs1 of instr in ID
//  id_rs2_i       in   5      rs2 of instr in ID
//  id_rs1_used_i  in   1      ID instr reads rs1
//  id_rs2_used_i  in   1      ID instr reads rs2
//  ex_rd_i        in   5      rd of instr in EX
//  ex_is_load_i   in   1      EX instr is a load
//  mispred_i      in   1      EX resolved control flow != always-taken prediction
//  lsu_busy_i     in   1      data memory access not complete this cycle
//  pc_en_o        out  1      PC register update enable
//  if_id_en_o     out  1      IF/ID enable
//  if_id_flush_o  out  1      IF/ID load NOP
//  id_ex_en_o     out  1      ID/EX enable
//  id_ex_flush_o  out  1      ID/EX load bubble
//  ex_mem_en_o    out  1      EX/MEM enable
//  redirect_o     out  1      PC mux selects EX correct target
//  state_o        out  2      FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH
//  stall_cnt_o    out  CNT_W  (PERF_CNT_EN) cycles with pc_en_o==0
//  flush_cnt_o    out  CNT_W  (PERF_CNT_EN) accepted mispredicts
// BEHAVIOUR
//  - Outputs combinational from state + inputs; state/counters registered.
//  - rst_i high: next state RUN, flush counter 0, perf counters 0; outputs while
//    rst_i high: all *_en_o 0, both flush 1, redirect_o 0.
//  - Default (RUN, no hazard): all enables 1, flushes 0, redirect_o 0.
//  - Priority each cycle: lsu_busy_i > mispred_i > load-use.
//  - lsu_busy_i=1 (any state): all enables 0, flushes 0, redirect_o 0; enter
//    MEM_WAIT, saving return state (RUN or FLUSH + remaining count, unchanged).
//    MEM_WAIT holds until lsu_busy_i=0; that same cycle acts as saved state.
//    mispred_i pending during freeze is acted on the cycle busy drops.
//  - Load-use = ex_is_load_i & ex_rd_i!=0 & ((rs1_used & rs1==rd)|(rs2_used & rs2==rd)).
//    In RUN only: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, others 1; stay RUN.
//    Exactly one bubble since load advances to MEM next cycle.
//  - mispred_i in RUN or FLUSH: redirect_o=1, pc_en_o=1, if_id_flush_o=1,
//    id_ex_flush_o=1, load-use ignored. FLUSH_CYCLES==1: stay RUN; else go FLUSH
//    with count=FLUSH_CYCLES-1 (reload if already in FLUSH).
//  - FLUSH: pc_en_o=1, if_id_flush_o=1, id_ex_en_o=1, redirect_o=0; count--;
//    at count==1 next state RUN. Load-use ignored (ID holds NOP).
//  - Illegal state_o value (3): next state RUN, outputs as RUN.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: stall_cnt_o/flush_cnt_o ports and counters present;
//  increment per rule above, saturate at all-ones, cleared by rst_i.
//  Undefined: ports and counters absent; control behaviour identical.
// TESTING
//  1 rst_i=1 two cycles -> enables 0, flushes 1; release -> state_o=0, all en=1.
//  2 ex_is_load=1, ex_rd=5, id_rs2=5, used2=1 -> 1 cycle pc_en=0, if_id_en=0,
//    id_ex_flush=1; next cycle (load gone) normal. Same with ex_rd=0 -> no stall.
//  3 FLUSH_CYCLES=3, mispred 1 cycle -> redirect=1 cycle 0; if_id_flush=1 cycles
//    0..2; state 2 cycles 1..2; RUN cycle 3.
//  4 lsu_busy=1 for 4 cycles during FLUSH count=2 -> all en=0 4 cycles, state_o=1;
//    then FLUSH resumes with 2 cycles remaining.
//  5 mispred + load-use + lsu_busy together -> freeze; busy drops -> redirect, no
//    load-use bubble. PERF_CNT_EN: stall_cnt=5, flush_cnt=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard information in, stage enable/flush controls out.
// The master modport is the pipeline datapath side; the slave modport is the controller side.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic [4:0] ex_rd_i;
    logic       ex_is_load_i;
    logic       mispred_i;
    logic       lsu_busy_i;
    logic       pc_en_o;
    logic       if_id_en_o;
    logic       if_id_flush_o;
    logic       id_ex_en_o;
    logic       id_ex_flush_o;
    logic       ex_mem_en_o;
    logic       redirect_o;
    logic [1:0] state_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        output ex_rd_i, ex_is_load_i, mispred_i, lsu_busy_i,
        input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o,
        input  id_ex_flush_o, ex_mem_en_o, redirect_o, state_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
        input  ex_rd_i, ex_is_load_i, mispred_i, lsu_busy_i,
        output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o,
        output id_ex_flush_o, ex_mem_en_o, redirect_o, state_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage always-taken pipeline (load-use, mispredict, LSU freeze).
// Optional perf counters (stall_cnt_o, flush_cnt_o) are built when PIPE_PERF_CNT_EN is defined.
//
// state    | meaning
// RUN      | normal issue; load-use bubbles and mispredicts handled here
// MEM_WAIT | LSU freeze; resumes the saved state (RUN or FLUSH) when busy drops
// FLUSH    | extra IF/ID flush cycles after a redirect, cnt_q cycles remain
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o,
`endif
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    state_t     ret_state_q, ret_state_d;
    state_t     eff_state;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;
    logic       accept_mispred;

    assign load_use = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) &&
                      ((bus.id_rs1_used_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
                       (bus.id_rs2_used_i && (bus.id_rs2_i == bus.ex_rd_i)));

    // Once busy drops, MEM_WAIT behaves exactly like the state it interrupted.
    always_comb begin
        eff_state = RUN;
        case (state_q)
            MEM_WAIT: eff_state = ret_state_q;
            FLUSH:    eff_state = FLUSH;
            default:  eff_state = RUN;
        endcase
    end

    always_comb begin
        state_d           = RUN;
        ret_state_d       = ret_state_q;
        cnt_d             = cnt_q;
        accept_mispred    = 1'b0;
        bus.pc_en_o       = 1'b1;
        bus.if_id_en_o    = 1'b1;
        bus.if_id_flush_o = 1'b0;
        bus.id_ex_en_o    = 1'b1;
        bus.id_ex_flush_o = 1'b0;
        bus.ex_mem_en_o   = 1'b1;
        bus.redirect_o    = 1'b0;
        if (rst_i) begin
            bus.pc_en_o       = 1'b0;
            bus.if_id_en_o    = 1'b0;
            bus.id_ex_en_o    = 1'b0;
            bus.ex_mem_en_o   = 1'b0;
            bus.if_id_flush_o = 1'b1;
            bus.id_ex_flush_o = 1'b1;
            ret_state_d       = RUN;
            cnt_d             = 4'd0;
        end else if (bus.lsu_busy_i) begin
            bus.pc_en_o     = 1'b0;
            bus.if_id_en_o  = 1'b0;
            bus.id_ex_en_o  = 1'b0;
            bus.ex_mem_en_o = 1'b0;
            state_d         = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_state_d = eff_state;
            end
        end else if (bus.mispred_i) begin
            accept_mispred    = 1'b1;
            bus.redirect_o    = 1'b1;
            bus.if_id_flush_o = 1'b1;
            bus.id_ex_flush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = 4'(FLUSH_CYCLES - 1);
            end
        end else if (eff_state == FLUSH) begin
            bus.if_id_flush_o = 1'b1;
            cnt_d             = cnt_q - 4'd1;
            state_d           = (cnt_q == 4'd1) ? RUN : FLUSH;
        end else if (load_use) begin
            bus.pc_en_o       = 1'b0;
            bus.if_id_en_o    = 1'b0;
            bus.id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        state_q     <= state_d;
        ret_state_q <= ret_state_d;
        cnt_q       <= cnt_d;
    end

    assign bus.state_o = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!bus.pc_en_o && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (accept_mispred && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept_mispred;
`endif

endmodule
